// File: rtl/wb_port_arbiter_pkg.sv
// Shared constants and types for the write-back port arbiter.
// Write-back source encodings match the existing MemtoReg select.
package wb_port_arbiter_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int REG_W_DEF  = 5;

   localparam logic       WB_SRC_ALU = 1'b0;
   localparam logic       WB_SRC_MEM = 1'b1;
   localparam logic [4:0] REG_ZERO   = 5'd0;

   typedef enum logic [1:0] {
      GNT_NONE = 2'd0,
      GNT_ALU  = 2'd1,
      GNT_MEM  = 2'd2
   } grant_e;

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Producer-side handshakes and register-file write port bundle.
// master = producers / register file side, slave = arbiter.
interface wb_port_arbiter_if #(
   parameter int DATA_W = 32,
   parameter int REG_W  = 5
);

   logic              alu_valid;
   logic              alu_ready;
   logic [REG_W-1:0]  alu_rd;
   logic [DATA_W-1:0] alu_data;

   logic              mem_valid;
   logic              mem_ready;
   logic [REG_W-1:0]  mem_rd;
   logic [DATA_W-1:0] mem_data;

   logic              RegWrite;
   logic [REG_W-1:0]  writeReg;
   logic [DATA_W-1:0] writeData;
   logic              MemtoReg;

   modport master (
      output alu_valid, alu_rd, alu_data,
      output mem_valid, mem_rd, mem_data,
      input  alu_ready, mem_ready,
      input  RegWrite, writeReg, writeData, MemtoReg
   );

   modport slave (
      input  alu_valid, alu_rd, alu_data,
      input  mem_valid, mem_rd, mem_data,
      output alu_ready, mem_ready,
      output RegWrite, writeReg, writeData, MemtoReg
   );

endinterface

// File: rtl/wb_fifo.sv
// Small count-based synchronous FIFO buffering ALU results.
// Push is ignored when full, pop is ignored when empty.
module wb_fifo #(
   parameter int WIDTH = 37,
   parameter int DEPTH = 2
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             do_push, do_pop;

   assign full  = (count_q == CW'(DEPTH));
   assign empty = (count_q == '0);
   assign rdata = mem_q[rd_ptr_q];

   // Next pointer/count; pointers wrap naturally since DEPTH is a power of 2.
   always_comb begin
      do_push  = push && !full;
      do_pop   = pop && !empty;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Pointer and occupancy state; reset empties the FIFO.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: entries are only read once counted valid.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata;
   end

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write port arbiter between buffered ALU results and
// unbuffered load results, with bounded starvation of the ALU FIFO.
module wb_port_arbiter
   import wb_port_arbiter_pkg::*;
#(
   parameter int DATA_W     = DATA_W_DEF,
   parameter int REG_W      = REG_W_DEF,
   parameter int DEPTH      = 2,
   parameter int STARVE_MAX = 2
)(
   input logic              clk,
   input logic              rst,
   wb_port_arbiter_if.slave bus
);

   localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
   localparam int EW = REG_W + DATA_W;

   logic              f_push, f_pop, f_full, f_empty;
   logic [EW-1:0]     f_wdata, f_rdata;
   logic [REG_W-1:0]  f_rd;
   logic [DATA_W-1:0] f_data;

   logic              alu_cand, starve_max;
   grant_e            grant;

   logic [SW-1:0]     starve_q, starve_d;
   logic              reg_write_q, reg_write_d;
   logic [REG_W-1:0]  write_reg_q, write_reg_d;
   logic [DATA_W-1:0] write_data_q, write_data_d;
   logic              memto_reg_q, memto_reg_d;

   assign f_wdata = {bus.alu_rd, bus.alu_data};
   assign f_rd    = f_rdata[DATA_W +: REG_W];
   assign f_data  = f_rdata[DATA_W-1:0];

   wb_fifo #(
      .WIDTH (EW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (f_push),
      .pop   (f_pop),
      .wdata (f_wdata),
      .rdata (f_rdata),
      .full  (f_full),
      .empty (f_empty)
   );

   // Grant selection: MEM preferred until the ALU has waited STARVE_MAX wins.
   always_comb begin
      alu_cand   = !f_empty;
      starve_max = (starve_q == SW'(STARVE_MAX));
      grant      = GNT_NONE;
      if (alu_cand && (!bus.mem_valid || starve_max)) grant = GNT_ALU;
      else if (bus.mem_valid)                         grant = GNT_MEM;
   end

   // Readys ignore the pop this cycle and mem_valid, so no comb loop forms.
   assign bus.alu_ready = !rst && !f_full;
   assign bus.mem_ready = !rst && !(alu_cand && starve_max);
   assign f_push        = bus.alu_valid && bus.alu_ready;
   assign f_pop         = (grant == GNT_ALU);

   // Starvation counter and next write-port contents from the winner.
   always_comb begin
      starve_d     = starve_q;
      reg_write_d  = 1'b0;
      write_reg_d  = write_reg_q;
      write_data_d = write_data_q;
      memto_reg_d  = memto_reg_q;
      if (!alu_cand) starve_d = '0;
      case (grant)
         GNT_ALU: begin
            starve_d     = '0;
            reg_write_d  = (f_rd != REG_W'(REG_ZERO));
            write_reg_d  = f_rd;
            write_data_d = f_data;
            memto_reg_d  = WB_SRC_ALU;
         end
         GNT_MEM: begin
            if (alu_cand && !starve_max) starve_d = starve_q + 1'b1;
            reg_write_d  = (bus.mem_rd != REG_W'(REG_ZERO));
            write_reg_d  = bus.mem_rd;
            write_data_d = bus.mem_data;
            memto_reg_d  = WB_SRC_MEM;
         end
         default: ;
      endcase
   end

   // Registered write port and arbitration state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         starve_q     <= '0;
         reg_write_q  <= 1'b0;
         write_reg_q  <= '0;
         write_data_q <= '0;
         memto_reg_q  <= WB_SRC_ALU;
      end else begin
         starve_q     <= starve_d;
         reg_write_q  <= reg_write_d;
         write_reg_q  <= write_reg_d;
         write_data_q <= write_data_d;
         memto_reg_q  <= memto_reg_d;
      end
   end

   assign bus.RegWrite  = reg_write_q;
   assign bus.writeReg  = write_reg_q;
   assign bus.writeData = write_data_q;
   assign bus.MemtoReg  = memto_reg_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed and randomized checks of wb_port_arbiter against a
// queue-based model of the arbitration rules.
module tb_wb_port_arbiter;

   localparam int DW    = 32;
   localparam int RW    = 5;
   localparam int DEPTH = 2;
   localparam int SMAX  = 2;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   wb_port_arbiter_if #(.DATA_W(DW), .REG_W(RW)) bus ();

   wb_port_arbiter #(
      .DATA_W     (DW),
      .REG_W      (RW),
      .DEPTH      (DEPTH),
      .STARVE_MAX (SMAX)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic [RW-1:0] rd;
      logic [DW-1:0] data;
   } ent_t;

   int checks = 0;
   int errors = 0;

   ent_t          q[$];
   int            starve;
   logic          m_rw, m_m2r;
   logic [RW-1:0] m_wr;
   logic [DW-1:0] m_wd;

   logic          o_ar, o_mr, o_rw, o_m2r;
   logic [RW-1:0] o_wr;
   logic [DW-1:0] o_wd;

   int e_src [8] = '{0, 0, 1, 1, 0, 1, 1, 0};
   int e_wr  [8] = '{0, 0, 7, 7, 5, 7, 7, 6};

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      q.delete();
      starve = 0;
      m_rw   = 1'b0;
      m_wr   = '0;
      m_wd   = '0;
      m_m2r  = 1'b0;
   endtask

   task automatic cyc(input logic av, input logic [RW-1:0] ard,
                      input logic [DW-1:0] adat, input logic mv,
                      input logic [RW-1:0] mrd, input logic [DW-1:0] mdat);
      logic e_ar, e_mr, cand;
      ent_t e;
      bus.alu_valid = av;
      bus.alu_rd    = ard;
      bus.alu_data  = adat;
      bus.mem_valid = mv;
      bus.mem_rd    = mrd;
      bus.mem_data  = mdat;
      @(negedge clk);
      o_ar  = bus.alu_ready;
      o_mr  = bus.mem_ready;
      o_rw  = bus.RegWrite;
      o_wr  = bus.writeReg;
      o_wd  = bus.writeData;
      o_m2r = bus.MemtoReg;
      cand  = (q.size() > 0);
      e_ar  = (q.size() < DEPTH);
      e_mr  = !(cand && starve == SMAX);
      chk("alu_ready", 64'(o_ar), 64'(e_ar));
      chk("mem_ready", 64'(o_mr), 64'(e_mr));
      chk("RegWrite", 64'(o_rw), 64'(m_rw));
      chk("writeReg", 64'(o_wr), 64'(m_wr));
      chk("writeData", 64'(o_wd), 64'(m_wd));
      chk("MemtoReg", 64'(o_m2r), 64'(m_m2r));
      if (cand && (!mv || starve == SMAX)) begin
         e      = q.pop_front();
         m_rw   = (e.rd != 0);
         m_wr   = e.rd;
         m_wd   = e.data;
         m_m2r  = 1'b0;
         starve = 0;
      end else if (mv) begin
         m_rw   = (mrd != 0);
         m_wr   = mrd;
         m_wd   = mdat;
         m_m2r  = 1'b1;
         starve = cand ? ((starve < SMAX) ? starve + 1 : SMAX) : 0;
      end else begin
         m_rw   = 1'b0;
         starve = 0;
      end
      if (av && e_ar) begin
         e.rd   = ard;
         e.data = adat;
         q.push_back(e);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      cyc(1'b0, '0, '0, 1'b0, '0, '0);
   endtask

   task automatic check_zeroed(input string tag);
      chk({tag, "_rw"}, 64'(bus.RegWrite), 64'd0);
      chk({tag, "_wr"}, 64'(bus.writeReg), 64'd0);
      chk({tag, "_wd"}, 64'(bus.writeData), 64'd0);
      chk({tag, "_m2r"}, 64'(bus.MemtoReg), 64'd0);
      chk({tag, "_ar"}, 64'(bus.alu_ready), 64'd0);
      chk({tag, "_mr"}, 64'(bus.mem_ready), 64'd0);
   endtask

   task automatic mid_reset(input string tag);
      rst = 1'b1;
      #1;
      check_zeroed(tag);
      model_reset();
      @(posedge clk);
      #1;
      check_zeroed(tag);
      rst = 1'b0;
   endtask

   initial begin
      rst           = 1'b1;
      bus.alu_valid = 1'b0;
      bus.alu_rd    = '0;
      bus.alu_data  = '0;
      bus.mem_valid = 1'b0;
      bus.mem_rd    = '0;
      bus.mem_data  = '0;
      model_reset();
      #1;
      check_zeroed("por");
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // ALU only
      idle();
      cyc(1'b1, 5'd3, 32'd23, 1'b0, '0, '0);
      idle();
      chk("t2_n1_rw", 64'(o_rw), 64'd0);
      idle();
      chk("t2_rw", 64'(o_rw), 64'd1);
      chk("t2_wr", 64'(o_wr), 64'd3);
      chk("t2_wd", 64'(o_wd), 64'd23);
      chk("t2_m2r", 64'(o_m2r), 64'd0);
      idle();
      chk("t2_n3_rw", 64'(o_rw), 64'd0);

      // MEM only
      cyc(1'b0, '0, '0, 1'b1, 5'd4, 32'd13);
      idle();
      chk("t3_rw", 64'(o_rw), 64'd1);
      chk("t3_wr", 64'(o_wr), 64'd4);
      chk("t3_wd", 64'(o_wd), 64'd13);
      chk("t3_m2r", 64'(o_m2r), 64'd1);

      // Contention with bounded starvation
      idle();
      for (int k = 0; k < 8; k++) begin
         cyc(k < 2, (k == 0) ? 5'd5 : 5'd6, (k == 0) ? 32'd55 : 32'd66,
             (k >= 1) && (k <= 6), 5'd7, 32'd77);
         if (k >= 2) begin
            chk("t4_src", 64'(o_m2r), 64'(e_src[k]));
            chk("t4_wr", 64'(o_wr), 64'(e_wr[k]));
            chk("t4_rw", 64'(o_rw), 64'd1);
         end
         if (k == 3 || k == 6) chk("t4_mem_ready", 64'(o_mr), 64'd0);
      end

      // Load to $zero
      idle();
      cyc(1'b0, '0, '0, 1'b1, 5'd0, 32'd99);
      chk("t5_mem_ready", 64'(o_mr), 64'd1);
      idle();
      chk("t5_rw", 64'(o_rw), 64'd0);
      chk("t5_m2r", 64'(o_m2r), 64'd1);
      chk("t5_wd", 64'(o_wd), 64'd99);

      // Full FIFO with pop and push offered in the same cycle
      idle();
      idle();
      for (int k = 0; k < 7; k++) begin
         cyc(k <= 4,
             (k == 0) ? 5'd10 : (k == 1) ? 5'd12 : 5'd13,
             (k == 0) ? 32'd100 : (k == 1) ? 32'd120 : 32'd130,
             k <= 3, 5'd11, 32'd111);
         if (k == 2 || k == 3) chk("t6_full_ready", 64'(o_ar), 64'd0);
         if (k == 4) chk("t6_reopen_ready", 64'(o_ar), 64'd1);
         if (k >= 4) begin
            chk("t6_order_wr", 64'(o_wr),
                (k == 4) ? 64'd10 : (k == 5) ? 64'd12 : 64'd13);
            chk("t6_order_m2r", 64'(o_m2r), 64'd0);
         end
      end

      // Reset mid-stream with two buffered ALU results
      idle();
      cyc(1'b1, 5'd20, 32'd200, 1'b1, 5'd21, 32'd210);
      cyc(1'b1, 5'd22, 32'd220, 1'b1, 5'd21, 32'd210);
      bus.alu_valid = 1'b1;
      bus.mem_valid = 1'b1;
      mid_reset("t1");
      for (int k = 0; k < 3; k++) begin
         idle();
         chk("t1_no_stale", 64'(o_rw), 64'd0);
         chk("t1_ar", 64'(o_ar), 64'd1);
         chk("t1_mr", 64'(o_mr), 64'd1);
      end

      // Randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         if (i == 200) mid_reset("rnd_rst");
         cyc(1'($urandom_range(0, 1)), RW'($urandom_range(0, 7)),
             DW'($urandom), ($urandom_range(0, 2) != 0),
             RW'($urandom_range(0, 7)), DW'($urandom));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
